host_bus_bridge: RTL
====================

// Module: host_bus_bridge
// PURPOSE
//  Parametrised host-CPU-to-VDP register bridge. Replaces the single-shot CSR/CSW latch.
//  Glitch-filters the chip selects and buffers host writes in a FIFO.
//  Issues ordered request/ack transactions to the VDP core and returns read data to the host bus.
//  Sits between the board pins (csr_n, csw_n, mode, cd) and the VDP REQ/WRT/ADR/DBO/DBI port.
// PARAMETERS
//  ADDR_W      2  host register-select width (mode pins)
//  DATA_W      8  data bus width
//  FIFO_DEPTH  4  write FIFO entries; power of 2, >=2
//  FILTER_LEN  3  consecutive equal samples needed to change a filtered chip select; >=1
// PORTS
//  clk         in   1       system clock (VDP clock domain)
//  reset       in   1       asynchronous, active-high reset
//  host_csr_n  in   1       raw host read strobe, asynchronous
//  host_csw_n  in   1       raw host write strobe, asynchronous
//  host_addr   in   ADDR_W  raw host register select
//  host_din    in   DATA_W  raw host write data
//  host_dout   out  DATA_W  last completed read data
//  host_oe     out  1       drive host bus; high while filtered csr_n is low
//  vdp_req     out  1       one-cycle request pulse to VDP
//  vdp_wrt     out  1       qualifies vdp_req: 1 = write, 0 = read
//  vdp_adr     out  ADDR_W  register select for the current request
//  vdp_dbo     out  DATA_W  write data for the current request
//  vdp_ack     in   1       one-cycle completion from VDP
//  vdp_dbi     in   DATA_W  read data; valid in the vdp_ack cycle
//  fifo_level  out  $clog2(FIFO_DEPTH)+1  current write-FIFO occupancy
//  overflow    out  1       sticky flag: a write was dropped because the FIFO was full
//  host_wait   out  1       present only with HOST_WAIT_EN
// BEHAVIOUR
//  Reset: all outputs 0, except host_dout=0 and host_oe=0. Filtered strobes=1, FIFO empty, FSM=IDLE.
//  Reset applies mid-transaction too: the outstanding request is abandoned and no late ack is consumed.
//  Raw inputs pass through a 2-flop synchroniser.
//  A filtered strobe changes only after FILTER_LEN identical synchronised samples.
//  host_addr/host_din are pipelined alongside, so captured values align with the filtered edge.
//  Write edge: a falling edge on filtered csw_n pushes {addr,data} into the FIFO.
//   If the FIFO is full, the write is dropped and overflow is set; it is cleared only by reset.
//  Read edge: a falling edge on filtered csr_n sets rd_pend.
//  Both falling edges in the same cycle: illegal; both are ignored and nothing changes.
//  FSM states: IDLE, WR_ISSUE, WR_WAIT, RD_ISSUE, RD_WAIT.
//   IDLE -> WR_ISSUE when the FIFO is not empty (writes take priority, which keeps ordering).
//   IDLE -> RD_ISSUE when rd_pend=1 and the FIFO is empty.
//   WR_ISSUE: vdp_req=1, vdp_wrt=1, adr/dbo from the FIFO head; pop; next WR_WAIT.
//   RD_ISSUE: vdp_req=1, vdp_wrt=0, adr=captured read addr; clear rd_pend; next RD_WAIT.
//   WR_WAIT / RD_WAIT: hold until vdp_ack, then go to IDLE. In RD_WAIT, the ack cycle loads host_dout<=vdp_dbi.
//   A vdp_ack seen outside the *_WAIT states is ignored.
//  vdp_adr/vdp_dbo are registered and hold their value until the next issue.
//  Push and pop in the same cycle: level unchanged, and the entry being pushed is never lost.
//  FIFO pointers wrap modulo FIFO_DEPTH; level counts 0..FIFO_DEPTH.
//  A read edge while rd_pend is already set merges into the pending read; the latest address wins.
//  Latency: raw csw_n fall -> vdp_req = 2 (sync) + FILTER_LEN + 1 (push) + 1 (issue) cycles, with the FIFO empty and FSM in IDLE.
// CONFIGURATION
//  HOST_WAIT_EN defined:
//   host_wait=1 from the filtered read edge until the cycle after host_dout updates.
//   host_wait=1 whenever level==FIFO_DEPTH.
//   Reset value 0.
//  HOST_WAIT_EN undefined: the port is absent and no wait logic is built.
// STRUCTURE
//  Package host_bus_pkg:
//   bridge_state_e (5-state enum).
//   bridge_wr_t struct {adr, dbo}.
//   Constants SYNC_STAGES=2 and the default widths.
//  Sub-module host_pin_filter (sync + FILTER_LEN run-length filter, reset value 1).
//   Instantiated for csr_n and csw_n.
//  FIFO is inline register array plus pointers; no vendor RAM.
// TESTING
//  1. Single write: csw_n low for 20 clk, addr=1, din=8'hA5.
//     -> exactly one vdp_req with wrt=1, adr=1, dbo=A5 at the stated latency; level back to 0 after the pop.
//  2. Glitch: csw_n low for FILTER_LEN-1 clk, then high.
//     -> no push, no vdp_req.
//  3. Burst: 6 writes while vdp_ack is stalled (DEPTH=4).
//     -> 4 entries issued in order; 1 more accepted after the first pop; later writes dropped, overflow=1 and sticky.
//  4. Ordering: 2 writes then a read at addr=1; VDP acks after 5 clk with dbi=8'h3C.
//     -> both writes issued before the read; host_dout=3C; host_oe tracks filtered csr_n.
//  5. Simultaneous csr_n/csw_n fall.
//     -> no push, no rd_pend, no vdp_req.
//  6. Reset asserted in RD_WAIT, then a late vdp_ack.
//     -> outputs 0, FSM IDLE, host_dout unchanged from its reset value 0.
//     With HOST_WAIT_EN: host_wait high during the read and while the FIFO is full.

Source files
------------

// File: rtl/host_bus_pkg.sv
// Shared types and defaults for the host-to-VDP register bridge.
package host_bus_pkg;

  localparam int SYNC_STAGES    = 2;
  localparam int DEF_ADDR_W     = 2;
  localparam int DEF_DATA_W     = 8;
  localparam int DEF_FIFO_DEPTH = 4;
  localparam int DEF_FILTER_LEN = 3;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    WR_ISSUE = 3'd1,
    WR_WAIT  = 3'd2,
    RD_ISSUE = 3'd3,
    RD_WAIT  = 3'd4
  } bridge_state_e;

  // Write-FIFO entry at the default bus widths.
  typedef struct packed {
    logic [DEF_ADDR_W-1:0] adr;
    logic [DEF_DATA_W-1:0] dbo;
  } bridge_wr_t;

endpackage

// File: rtl/host_pin_filter.sv
// Two-flop synchroniser followed by a run-length filter: the output only follows
// the input after FILTER_LEN consecutive identical samples. Idles high.
module host_pin_filter
  import host_bus_pkg::*;
#(
  parameter int FILTER_LEN = DEF_FILTER_LEN
) (
  input  logic clk,
  input  logic reset,
  input  logic i_raw,
  output logic o_filt
);

  localparam int CNT_W = $clog2(FILTER_LEN) + 1;

  logic [SYNC_STAGES-1:0] r_sync;
  logic [CNT_W-1:0]       r_cnt;
  logic                   r_filt;
  logic                   w_sample;

  assign w_sample = r_sync[SYNC_STAGES-1];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sync <= '1;
      r_cnt  <= '0;
      r_filt <= 1'b1;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_raw};
      if (w_sample == r_filt) begin
        r_cnt <= '0;
      end else if (r_cnt == CNT_W'(FILTER_LEN - 1)) begin
        r_filt <= w_sample;
        r_cnt  <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign o_filt = r_filt;

endmodule

// File: rtl/host_bus_bridge.sv
// Host-CPU to VDP register bridge: filtered strobes, buffered writes, ordered req/ack.
// Define HOST_WAIT_EN to build the host_wait output and its logic.
module host_bus_bridge
  import host_bus_pkg::*;
#(
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int DATA_W     = DEF_DATA_W,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
  parameter int FILTER_LEN = DEF_FILTER_LEN
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          host_csr_n,
  input  logic                          host_csw_n,
  input  logic [ADDR_W-1:0]             host_addr,
  input  logic [DATA_W-1:0]             host_din,
  output logic [DATA_W-1:0]             host_dout,
  output logic                          host_oe,
  output logic                          vdp_req,
  output logic                          vdp_wrt,
  output logic [ADDR_W-1:0]             vdp_adr,
  output logic [DATA_W-1:0]             vdp_dbo,
  input  logic                          vdp_ack,
  input  logic [DATA_W-1:0]             vdp_dbi,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          overflow
`ifdef HOST_WAIT_EN
  ,
  output logic                          host_wait
`endif
);

  localparam int PTR_W    = $clog2(FIFO_DEPTH);
  localparam int LVL_W    = PTR_W + 1;
  localparam int ENT_W    = ADDR_W + DATA_W;
  localparam int PIPE_LEN = SYNC_STAGES + FILTER_LEN;

  typedef struct packed {
    logic [ADDR_W-1:0] adr;
    logic [DATA_W-1:0] dbo;
  } wr_entry_t;

  logic                           w_csr_filt;
  logic                           w_csw_filt;
  logic                           r_csr_prev;
  logic                           r_csw_prev;
  logic                           w_rd_fall;
  logic                           w_wr_fall;
  logic                           w_rd_evt;
  logic                           w_wr_evt;
  logic [PIPE_LEN-1:0][ENT_W-1:0] r_pipe;
  wr_entry_t                      w_cap;

  wr_entry_t                      r_fifo [FIFO_DEPTH];
  logic [PTR_W-1:0]               r_wr_ptr;
  logic [PTR_W-1:0]               r_rd_ptr;
  logic [LVL_W-1:0]               r_level;
  logic                           w_full;
  logic                           w_empty;
  logic                           w_push;
  logic                           w_pop;
  logic                           w_drop;
  logic                           r_overflow;

  bridge_state_e                  r_state;
  bridge_state_e                  w_state_next;
  logic                           w_req;
  logic                           w_wrt;
  logic                           w_load_wr;
  logic                           w_load_rd;
  logic                           w_rd_issue;
  logic                           w_rd_done;
  logic                           r_rd_pend;
  logic [ADDR_W-1:0]              r_rd_addr;
  logic [ADDR_W-1:0]              r_vdp_adr;
  logic [DATA_W-1:0]              r_vdp_dbo;
  logic [DATA_W-1:0]              r_host_dout;

  host_pin_filter #(.FILTER_LEN(FILTER_LEN)) u_csr_filt (
    .clk    (clk),
    .reset  (reset),
    .i_raw  (host_csr_n),
    .o_filt (w_csr_filt)
  );

  host_pin_filter #(.FILTER_LEN(FILTER_LEN)) u_csw_filt (
    .clk    (clk),
    .reset  (reset),
    .i_raw  (host_csw_n),
    .o_filt (w_csw_filt)
  );

  // Address/data delayed by the strobe path depth so the captured value is the
  // one present when the raw strobe fell.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pipe     <= '0;
      r_csr_prev <= 1'b1;
      r_csw_prev <= 1'b1;
    end else begin
      r_pipe     <= {r_pipe[PIPE_LEN-2:0], {host_addr, host_din}};
      r_csr_prev <= w_csr_filt;
      r_csw_prev <= w_csw_filt;
    end
  end

  assign w_cap     = r_pipe[PIPE_LEN-1];
  assign w_rd_fall = r_csr_prev & ~w_csr_filt;
  assign w_wr_fall = r_csw_prev & ~w_csw_filt;
  assign w_rd_evt  = w_rd_fall & ~w_wr_fall;
  assign w_wr_evt  = w_wr_fall & ~w_rd_fall;

  assign w_full  = (r_level == LVL_W'(FIFO_DEPTH));
  assign w_empty = (r_level == '0);
  // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
  assign w_push  = w_wr_evt & (~w_full | w_pop);
  assign w_drop  = w_wr_evt & w_full & ~w_pop;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo[r_wr_ptr] <= w_cap;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_level    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
      if (w_drop) r_overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    w_req        = 1'b0;
    w_wrt        = 1'b0;
    w_load_wr    = 1'b0;
    w_load_rd    = 1'b0;
    w_pop        = 1'b0;
    w_rd_issue   = 1'b0;
    w_rd_done    = 1'b0;
    case (r_state)
      IDLE: begin
        if (!w_empty) begin
          w_state_next = WR_ISSUE;
          w_load_wr    = 1'b1;
        end else if (r_rd_pend) begin
          w_state_next = RD_ISSUE;
          w_load_rd    = 1'b1;
        end
      end
      WR_ISSUE: begin
        w_req        = 1'b1;
        w_wrt        = 1'b1;
        w_pop        = 1'b1;
        w_state_next = WR_WAIT;
      end
      RD_ISSUE: begin
        w_req        = 1'b1;
        w_rd_issue   = 1'b1;
        w_state_next = RD_WAIT;
      end
      WR_WAIT: begin
        if (vdp_ack) w_state_next = IDLE;
      end
      RD_WAIT: begin
        if (vdp_ack) begin
          w_rd_done    = 1'b1;
          w_state_next = IDLE;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  // A new read edge wins over the clear so a read arriving during issue is not lost.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rd_pend   <= 1'b0;
      r_rd_addr   <= '0;
      r_vdp_adr   <= '0;
      r_vdp_dbo   <= '0;
      r_host_dout <= '0;
    end else begin
      if (w_rd_evt) begin
        r_rd_pend <= 1'b1;
        r_rd_addr <= w_cap.adr;
      end else if (w_rd_issue) begin
        r_rd_pend <= 1'b0;
      end
      if (w_load_wr) begin
        r_vdp_adr <= r_fifo[r_rd_ptr].adr;
        r_vdp_dbo <= r_fifo[r_rd_ptr].dbo;
      end else if (w_load_rd) begin
        r_vdp_adr <= r_rd_addr;
      end
      if (w_rd_done) r_host_dout <= vdp_dbi;
    end
  end

`ifdef HOST_WAIT_EN
  logic r_rd_wait;
  logic r_dout_upd;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rd_wait  <= 1'b0;
      r_dout_upd <= 1'b0;
    end else begin
      r_dout_upd <= w_rd_done;
      if (w_rd_evt)                      r_rd_wait <= 1'b1;
      else if (r_dout_upd && !r_rd_pend) r_rd_wait <= 1'b0;
    end
  end

  assign host_wait = r_rd_wait | w_full;
`endif

  assign host_dout  = r_host_dout;
  assign host_oe    = ~w_csr_filt;
  assign vdp_req    = w_req;
  assign vdp_wrt    = w_wrt;
  assign vdp_adr    = r_vdp_adr;
  assign vdp_dbo    = r_vdp_dbo;
  assign fifo_level = r_level;
  assign overflow   = r_overflow;

endmodule
